// File: rtl/cube_color_sequencer_if.sv
// Signal bundle between the NIOS / Q*bert layer (master) and the cube colour
// sequencer (slave). The clock and reset are kept outside the bundle.
`timescale 1ns/1ps
interface cube_color_sequencer_if #(
  parameter int N_CUBE = 28
);
  logic              e_start_qb;
  logic              e_pause_qb;
  logic [1:0]        e_color_mode;
  logic              e_level_ack;
  logic              done_move;
  logic [N_CUBE-1:0] position_qb;

  logic [N_CUBE-1:0] color_state;
  logic [4:0]        cubes_left;
  logic [15:0]       score;
  logic [4:0]        landed_idx;
  logic              level_done;
  logic              busy;

  modport master (
    output e_start_qb, e_pause_qb, e_color_mode, e_level_ack, done_move, position_qb,
    input  color_state, cubes_left, score, landed_idx, level_done, busy
  );

  modport slave (
    input  e_start_qb, e_pause_qb, e_color_mode, e_level_ack, done_move, position_qb,
    output color_state, cubes_left, score, landed_idx, level_done, busy
  );
endinterface

// File: rtl/cube_color_sequencer.sv
// Game-state controller for the cube pyramid: accepts landings, waits for the
// hitbox flags to settle, recolours the landed cube and tracks score/level end.
`timescale 1ns/1ps
module cube_color_sequencer #(
  parameter int N_CUBE = 28,
  parameter int SETTLE = 2,
  parameter int POINTS = 25,
  parameter int BONUS  = 1000
) (
  input  logic                  CLK_33,
  input  logic                  reset,
  cube_color_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_APPLY,
    S_DONE
  } state_t;

  localparam logic [4:0]  OFF_MAP     = 5'd31;
  localparam logic [4:0]  FULL_LEFT   = 5'(N_CUBE);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [16:0] POINTS_W    = 17'(POINTS);
  localparam logic [16:0] BONUS_W     = 17'(BONUS);
  localparam logic [16:0] SCORE_MAX   = 17'h0_FFFF;

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [1:0]        mode_q;
  logic [N_CUBE-1:0] color_q;
  logic [4:0]        left_q;
  logic [15:0]       score_q;
  logic [4:0]        idx_q;
  logic              done_q;
  logic              busy_q;

  // Lowest-index landing flag and the resulting board update.
  logic              hit;
  logic [4:0]        hit_idx;
  logic [N_CUBE-1:0] hit_mask;
  logic [N_CUBE-1:0] next_color;
  logic [4:0]        next_left;
  logic [16:0]       score_sum;
  logic [15:0]       next_score;
  logic              level_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = OFF_MAP;
    hit_mask = '0;
    for (int i = N_CUBE - 1; i >= 0; i--) begin
      if (bus.position_qb[i]) begin
        hit         = 1'b1;
        hit_idx     = 5'(i);
        hit_mask    = '0;
        hit_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    next_color = color_q;
    next_left  = left_q;
    score_sum  = {1'b0, score_q};
    level_hit  = 1'b0;
    if (hit) begin
      if ((color_q & hit_mask) == '0) begin
        next_color = color_q | hit_mask;
        next_left  = (left_q == 5'd0) ? 5'd0 : left_q - 5'd1;
        score_sum  = score_sum + POINTS_W;
      end else if (mode_q == 2'd1) begin
        next_color = color_q & ~hit_mask;
        next_left  = (left_q >= FULL_LEFT) ? FULL_LEFT : left_q + 5'd1;
      end
      level_hit = (next_left == 5'd0);
      if (level_hit) begin
        score_sum = score_sum + BONUS_W;
      end
    end
    next_score = (score_sum > SCORE_MAX) ? 16'hFFFF : score_sum[15:0];
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      mode_q     <= 2'd0;
      color_q    <= '0;
      left_q     <= 5'd0;
      score_q    <= 16'd0;
      idx_q      <= OFF_MAP;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (bus.e_start_qb) begin
      // Start wins over any landing, ack or pending apply; score survives.
      state      <= S_RUN;
      settle_cnt <= 4'd0;
      mode_q     <= bus.e_color_mode;
      color_q    <= '0;
      left_q     <= FULL_LEFT;
      idx_q      <= OFF_MAP;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_RUN: begin
          if (bus.done_move && !bus.e_pause_qb) begin
            state      <= S_SETTLE;
            settle_cnt <= 4'd0;
            busy_q     <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_APPLY;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_APPLY: begin
          busy_q <= 1'b0;
          idx_q  <= hit_idx;
          state  <= S_RUN;
          if (hit) begin
            color_q <= next_color;
            left_q  <= next_left;
            score_q <= next_score;
            if (level_hit) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.e_level_ack) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.color_state = color_q;
  assign bus.cubes_left  = left_q;
  assign bus.score       = score_q;
  assign bus.landed_idx  = idx_q;
  assign bus.level_done  = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cube_color_sequencer.sv
// Self-checking bench for cube_color_sequencer: a reference model pushes the
// expected board after each landing and the bench pops it when the DUT applies.
`timescale 1ns/1ps
module tb_cube_color_sequencer;
  localparam int N      = 28;
  localparam int SETTLE = 2;

  logic CLK_33 = 1'b0;
  logic reset  = 1'b1;

  cube_color_sequencer_if #(.N_CUBE(N)) bus ();

  cube_color_sequencer #(
    .N_CUBE(N), .SETTLE(SETTLE), .POINTS(25), .BONUS(1000)
  ) dut (
    .CLK_33(CLK_33),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLK_33 = ~CLK_33;

  typedef struct {
    logic [N-1:0] color;
    logic [4:0]   left;
    logic [15:0]  score;
    logic [4:0]   idx;
    logic         done;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] m_color;
  int           m_left;
  int           m_score;
  logic [1:0]   m_mode;

  task automatic tick();
    @(posedge CLK_33);
    #1;
  endtask

  task automatic model_reset();
    m_color = '0;
    m_left  = 0;
    m_score = 0;
    m_mode  = 2'd0;
  endtask

  task automatic model_start(input logic [1:0] mode);
    m_color = '0;
    m_left  = N;
    m_mode  = mode;
  endtask

  task automatic model_land(input logic [N-1:0] pos);
    exp_t e;
    int   idx;
    idx    = -1;
    e.done = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pos[i] && idx < 0) idx = i;
    end
    if (idx < 0) begin
      e.idx = 5'd31;
    end else begin
      e.idx = 5'(idx);
      if (!m_color[idx]) begin
        m_color[idx] = 1'b1;
        m_left       = m_left - 1;
        m_score      = m_score + 25;
      end else if (m_mode == 2'd1) begin
        m_color[idx] = 1'b0;
        m_left       = m_left + 1;
      end
      if (m_left == 0) begin
        m_score = m_score + 1000;
        e.done  = 1'b1;
      end
    end
    if (m_score > 65535) m_score = 65535;
    e.color = m_color;
    e.left  = 5'(m_left);
    e.score = 16'(m_score);
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] mode);
    bus.e_start_qb   = 1'b1;
    bus.e_color_mode = mode;
    tick();
    bus.e_start_qb = 1'b0;
    model_start(mode);
  endtask

  // One landing: e0 accepts it, then the update must appear after SETTLE+1 edges.
  task automatic land(input logic [N-1:0] pos, input bit second_pulse);
    exp_t e;
    int   n;
    bus.position_qb = pos;
    bus.done_move   = 1'b1;
    model_land(pos);
    tick();
    bus.done_move = second_pulse;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL land_busy: got %b expected 1", bus.busy);
    end
    tick();
    bus.done_move = 1'b0;
    n = 1;
    while (bus.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== SETTLE + 1) begin
      n_bad++;
      $display("FAIL land_latency: got %0d edges expected %0d", n, SETTLE + 1);
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.color_state !== e.color) begin
      n_bad++;
      $display("FAIL sb_color: got %h expected %h", bus.color_state, e.color);
    end
    n_cmp++;
    if (bus.cubes_left !== e.left) begin
      n_bad++;
      $display("FAIL sb_left: got %0d expected %0d", bus.cubes_left, e.left);
    end
    n_cmp++;
    if (bus.score !== e.score) begin
      n_bad++;
      $display("FAIL sb_score: got %0d expected %0d", bus.score, e.score);
    end
    n_cmp++;
    if (bus.landed_idx !== e.idx) begin
      n_bad++;
      $display("FAIL sb_idx: got %0d expected %0d", bus.landed_idx, e.idx);
    end
    n_cmp++;
    if (bus.level_done !== e.done) begin
      n_bad++;
      $display("FAIL sb_level_done: got %b expected %b", bus.level_done, e.done);
    end
    if (second_pulse) begin
      tick();
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL second_pulse_dropped: busy got %b expected 0", bus.busy);
      end
    end
  endtask

  task automatic test_reset(input string name);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    sb.delete();
    n_cmp++;
    if (bus.color_state !== '0 || bus.cubes_left !== 5'd0 || bus.score !== 16'd0 ||
        bus.landed_idx !== 5'd31 || bus.level_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got color=%h left=%0d score=%0d idx=%0d done=%b busy=%b expected 0/0/0/31/0/0",
               name, bus.color_state, bus.cubes_left, bus.score, bus.landed_idx,
               bus.level_done, bus.busy);
    end
  endtask

  task automatic test_set_only();
    test_reset("reset_before_set");
    do_start(2'd0);
    land(N'(1) << 5, 1'b0);
    n_cmp++;
    if (bus.color_state !== 28'h0000020 || bus.cubes_left !== 5'd27 ||
        bus.score !== 16'd25 || bus.landed_idx !== 5'd5) begin
      n_bad++;
      $display("FAIL set_only: got color=%h left=%0d score=%0d idx=%0d expected 0000020/27/25/5",
               bus.color_state, bus.cubes_left, bus.score, bus.landed_idx);
    end
  endtask

  task automatic test_toggle();
    logic [1:0] modes [3];
    modes[0] = 2'd1;
    modes[1] = 2'd0;
    modes[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      test_reset("reset_before_toggle");
      do_start(modes[k]);
      land(N'(1) << 3, 1'b0);
      land(N'(1) << 3, 1'b0);
      n_cmp++;
      if (modes[k] == 2'd1) begin
        if (bus.color_state[3] !== 1'b0 || bus.cubes_left !== 5'd28 || bus.score !== 16'd25) begin
          n_bad++;
          $display("FAIL toggle_mode1: got bit3=%b left=%0d score=%0d expected 0/28/25",
                   bus.color_state[3], bus.cubes_left, bus.score);
        end
      end else begin
        if (bus.color_state[3] !== 1'b1 || bus.cubes_left !== 5'd27 || bus.score !== 16'd25) begin
          n_bad++;
          $display("FAIL toggle_setonly_mode%0d: got bit3=%b left=%0d score=%0d expected 1/27/25",
                   modes[k], bus.color_state[3], bus.cubes_left, bus.score);
        end
      end
    end
  endtask

  task automatic test_dropped();
    test_reset("reset_before_dropped");
    do_start(2'd0);
    bus.e_pause_qb  = 1'b1;
    bus.position_qb = N'(1) << 6;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL paused_busy: got %b expected 0", bus.busy);
    end
    repeat (4) tick();
    n_cmp++;
    if (bus.color_state !== '0 || bus.cubes_left !== 5'd28) begin
      n_bad++;
      $display("FAIL paused_nochange: got color=%h left=%0d expected 0/28",
               bus.color_state, bus.cubes_left);
    end
    bus.e_pause_qb = 1'b0;
    land(N'(1) << 6, 1'b1);
    land('0, 1'b0);
    n_cmp++;
    if (bus.landed_idx !== 5'd31 || bus.color_state !== (N'(1) << 6)) begin
      n_bad++;
      $display("FAIL offmap: got idx=%0d color=%h expected 31/%h",
               bus.landed_idx, bus.color_state, N'(1) << 6);
    end
    land((N'(1) << 4) | (N'(1) << 9), 1'b0);
    n_cmp++;
    if (bus.landed_idx !== 5'd4) begin
      n_bad++;
      $display("FAIL priority_idx: got %0d expected 4", bus.landed_idx);
    end
  endtask

  task automatic test_start_priority();
    test_reset("reset_before_start_prio");
    do_start(2'd0);
    land(N'(1) << 2, 1'b0);
    land(N'(1) << 7, 1'b0);
    // Start and landing in the same RUN cycle.
    bus.position_qb  = N'(1) << 10;
    bus.done_move    = 1'b1;
    bus.e_start_qb   = 1'b1;
    bus.e_color_mode = 2'd0;
    tick();
    bus.done_move  = 1'b0;
    bus.e_start_qb = 1'b0;
    model_start(2'd0);
    repeat (5) tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.color_state !== '0 || bus.cubes_left !== 5'd28 ||
        bus.score !== 16'(m_score)) begin
      n_bad++;
      $display("FAIL start_with_move: got busy=%b color=%h left=%0d score=%0d expected 0/0/28/%0d",
               bus.busy, bus.color_state, bus.cubes_left, bus.score, m_score);
    end
    // Start while a landing is settling.
    land(N'(1) << 8, 1'b0);
    bus.position_qb = N'(1) << 11;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move = 1'b0;
    tick();
    bus.e_start_qb = 1'b1;
    tick();
    bus.e_start_qb = 1'b0;
    model_start(2'd0);
    repeat (5) tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.color_state !== '0 || bus.cubes_left !== 5'd28 ||
        bus.score !== 16'(m_score) || bus.score !== 16'd75) begin
      n_bad++;
      $display("FAIL start_in_settle: got busy=%b color=%h left=%0d score=%0d expected 0/0/28/75",
               bus.busy, bus.color_state, bus.cubes_left, bus.score);
    end
  endtask

  task automatic test_level_complete();
    test_reset("reset_before_level");
    do_start(2'd0);
    for (int i = 0; i < N; i++) begin
      land(N'(1) << i, 1'b0);
    end
    n_cmp++;
    if (bus.level_done !== 1'b1 || bus.score !== 16'd1700) begin
      n_bad++;
      $display("FAIL level_done: got done=%b score=%0d expected 1/1700", bus.level_done, bus.score);
    end
    bus.position_qb = N'(1);
    bus.done_move   = 1'b1;
    tick();
    bus.done_move = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.level_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL level_hold: got done=%b busy=%b expected 1/0", bus.level_done, bus.busy);
    end
    bus.e_level_ack = 1'b1;
    tick();
    bus.e_level_ack = 1'b0;
    n_cmp++;
    if (bus.level_done !== 1'b0) begin
      n_bad++;
      $display("FAIL level_ack: got %b expected 0", bus.level_done);
    end
    bus.done_move = 1'b1;
    tick();
    bus.done_move = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.color_state !== {N{1'b1}}) begin
      n_bad++;
      $display("FAIL idle_after_ack: got busy=%b color=%h expected 0/%h",
               bus.busy, bus.color_state, {N{1'b1}});
    end
  endtask

  task automatic test_saturation();
    int level;
    bit extra;
    test_reset("reset_before_sat");
    level = 0;
    extra = 1'b0;
    while (!extra && level < 60) begin
      if (m_score == 65535) extra = 1'b1;
      do_start(2'd0);
      n_cmp++;
      if (bus.level_done !== 1'b0 || bus.cubes_left !== 5'd28) begin
        n_bad++;
        $display("FAIL sat_start_clear: got done=%b left=%0d expected 0/28",
                 bus.level_done, bus.cubes_left);
      end
      for (int i = 0; i < N; i++) begin
        land(N'(1) << i, 1'b0);
      end
      if (level[0]) begin
        bus.e_level_ack = 1'b1;
        tick();
        bus.e_level_ack = 1'b0;
      end
      level++;
    end
    n_cmp++;
    if (bus.score !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL score_clamp: got %h expected ffff", bus.score);
    end
    // Reset while a landing is settling: outputs clear and the landing is lost.
    do_start(2'd0);
    bus.position_qb = N'(1) << 12;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move = 1'b0;
    tick();
    test_reset("reset_mid_settle");
    bus.done_move = 1'b1;
    tick();
    bus.done_move = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.color_state !== '0 || bus.landed_idx !== 5'd31) begin
      n_bad++;
      $display("FAIL after_reset_idle: got busy=%b color=%h idx=%0d expected 0/0/31",
               bus.busy, bus.color_state, bus.landed_idx);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.e_start_qb   = 1'b0;
    bus.e_pause_qb   = 1'b0;
    bus.e_color_mode = 2'd0;
    bus.e_level_ack  = 1'b0;
    bus.done_move    = 1'b0;
    bus.position_qb  = '0;
    model_reset();
    tick();
    test_reset("reset_initial");
    test_set_only();
    test_toggle();
    test_dropped();
    test_start_priority();
    test_level_complete();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
